// File: rtl/voice_allocator_if.sv
// Event and key-write bundle between the MIDI decoder, the voice allocator and
// the per-voice pitch path.
//
// Handshake: the source drives ev_valid with ev_on/ev_key/ev_vel and holds all
// of them unchanged until it sees ev_valid && ev_ready at a rising data_clk
// edge; that edge is the transfer. ev_ready never depends on ev_valid.
// note_on is a one-cycle strobe. cur_key_adr/cur_key_val are already stable in
// the cycle before it rises.
interface voice_allocator_if #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
);
    logic               ev_valid;
    logic               ev_ready;
    logic               ev_on;
    logic [6:0]         ev_key;
    logic [6:0]         ev_vel;
    logic               all_off;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic               note_on;
    logic [VOICES-1:0]  voice_gate;
    logic               steal;
    logic [V_WIDTH:0]   active_cnt;
    logic [1:0]         fsm_state;

    modport master (
        output ev_valid, ev_on, ev_key, ev_vel, all_off,
        input  ev_ready, cur_key_adr, cur_key_val, note_on, voice_gate,
               steal, active_cnt, fsm_state
    );

    modport slave (
        input  ev_valid, ev_on, ev_key, ev_vel, all_off,
        output ev_ready, cur_key_adr, cur_key_val, note_on, voice_gate,
               steal, active_cnt, fsm_state
    );
endinterface

// File: rtl/voice_allocator.sv
// Voice allocator: scans all voices for each note event, then retriggers a
// voice already holding the key, takes the lowest free voice, or steals the
// oldest one. It writes the chosen voice/key to the pitch path and strobes
// note_on. fsm_state exposes the controller state for debug.
module voice_allocator #(
    parameter int VOICES    = 8,
    parameter int V_WIDTH   = 3,
    parameter int AGE_WIDTH = 4
) (
    input  logic              data_clk,
    input  logic              reset_data,
    voice_allocator_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] STROBE = 2'd3;

    localparam logic [AGE_WIDTH-1:0] AGE_MAX  = {AGE_WIDTH{1'b1}};
    localparam logic [V_WIDTH-1:0]   IDX_LAST = V_WIDTH'(VOICES - 1);

    logic [1:0]           state_q, state_d;
    logic [V_WIDTH-1:0]   idx_q, idx_d;
    logic                 on_q, on_d;
    logic [6:0]           ev_key_q, ev_key_d;
    logic                 m_found_q, m_found_d;
    logic [V_WIDTH-1:0]   m_idx_q, m_idx_d;
    logic                 f_found_q, f_found_d;
    logic [V_WIDTH-1:0]   f_idx_q, f_idx_d;
    logic [V_WIDTH-1:0]   o_idx_q, o_idx_d;
    logic [AGE_WIDTH-1:0] o_age_q, o_age_d;
    logic                 steal_pend_q, steal_pend_d;
    logic [V_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]           val_q, val_d;
    logic                 note_on_q, note_on_d;
    logic                 steal_q, steal_d;
    logic [VOICES-1:0]    gate_q, gate_d;
    logic [V_WIDTH:0]     cnt_q, cnt_d;
    logic [6:0]           key_q [VOICES];
    logic [6:0]           key_d [VOICES];
    logic [AGE_WIDTH-1:0] age_q [VOICES];
    logic [AGE_WIDTH-1:0] age_d [VOICES];

    // Candidates after folding in the voice visited this cycle.
    logic                 m_found_c;
    logic [V_WIDTH-1:0]   m_idx_c;
    logic                 f_found_c;
    logic [V_WIDTH-1:0]   f_idx_c;
    logic [V_WIDTH-1:0]   o_idx_c;
    logic [AGE_WIDTH-1:0] o_age_c;
    logic [V_WIDTH-1:0]   tgt_c;
    logic [V_WIDTH:0]     pop_c;

    // Fold the currently visited voice into the match/free/oldest candidates.
    always_comb begin
        m_found_c = m_found_q;
        m_idx_c   = m_idx_q;
        f_found_c = f_found_q;
        f_idx_c   = f_idx_q;
        o_idx_c   = o_idx_q;
        o_age_c   = o_age_q;
        if (!m_found_q && gate_q[idx_q] && (key_q[idx_q] == ev_key_q)) begin
            m_found_c = 1'b1;
            m_idx_c   = idx_q;
        end
        if (!f_found_q && !gate_q[idx_q]) begin
            f_found_c = 1'b1;
            f_idx_c   = idx_q;
        end
        // Strictly greater, so ties stay with the lowest index.
        if (age_q[idx_q] > o_age_q) begin
            o_idx_c = idx_q;
            o_age_c = age_q[idx_q];
        end
        if (m_found_c) begin
            tgt_c = m_idx_c;
        end else if (f_found_c) begin
            tgt_c = f_idx_c;
        end else begin
            tgt_c = o_idx_c;
        end
    end

    // Registered gate count source.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < VOICES; i++) begin
            pop_c = pop_c + (V_WIDTH + 1)'(gate_q[i]);
        end
    end

    // Controller next state. The allocation is written on the edge that ends
    // the last scan visit, so the new adr/val show during COMMIT, one cycle
    // ahead of the strobe.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        on_d         = on_q;
        ev_key_d     = ev_key_q;
        m_found_d    = m_found_c;
        m_idx_d      = m_idx_c;
        f_found_d    = f_found_c;
        f_idx_d      = f_idx_c;
        o_idx_d      = o_idx_c;
        o_age_d      = o_age_c;
        steal_pend_d = steal_pend_q;
        adr_d        = adr_q;
        val_d        = val_q;
        note_on_d    = 1'b0;
        steal_d      = 1'b0;
        gate_d       = gate_q;
        cnt_d        = pop_c;
        key_d        = key_q;
        age_d        = age_q;

        case (state_q)
            IDLE: begin
                m_found_d = 1'b0;
                m_idx_d   = '0;
                f_found_d = 1'b0;
                f_idx_d   = '0;
                o_idx_d   = '0;
                o_age_d   = '0;
                if (bus.ev_valid) begin
                    on_d     = bus.ev_on && (bus.ev_vel != 7'd0);
                    ev_key_d = bus.ev_key;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = COMMIT;
                    if (on_q) begin
                        steal_pend_d = !m_found_c && !f_found_c;
                        adr_d        = tgt_c;
                        val_d        = {1'b0, ev_key_q};
                        for (int i = 0; i < VOICES; i++) begin
                            if (V_WIDTH'(i) == tgt_c) begin
                                gate_d[i] = 1'b1;
                                key_d[i]  = ev_key_q;
                                age_d[i]  = '0;
                            end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
                                age_d[i] = age_q[i] + AGE_WIDTH'(1);
                            end
                        end
                    end else if (m_found_c) begin
                        gate_d[m_idx_c] = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + V_WIDTH'(1);
                end
            end
            COMMIT: begin
                if (on_q) begin
                    note_on_d = 1'b1;
                    steal_d   = steal_pend_q;
                    state_d   = STROBE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // all_off overrides everything but reset and drops any event.
        if (bus.all_off) begin
            gate_d    = '0;
            cnt_d     = '0;
            note_on_d = 1'b0;
            steal_d   = 1'b0;
            state_d   = IDLE;
        end
    end

    // State and per-voice storage registers with synchronous reset.
    always_ff @(posedge data_clk) begin
        if (reset_data) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            on_q         <= 1'b0;
            ev_key_q     <= '0;
            m_found_q    <= 1'b0;
            m_idx_q      <= '0;
            f_found_q    <= 1'b0;
            f_idx_q      <= '0;
            o_idx_q      <= '0;
            o_age_q      <= '0;
            steal_pend_q <= 1'b0;
            adr_q        <= '0;
            val_q        <= 8'hFF;
            note_on_q    <= 1'b0;
            steal_q      <= 1'b0;
            gate_q       <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_q[i] <= 7'h7F;
                age_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            on_q         <= on_d;
            ev_key_q     <= ev_key_d;
            m_found_q    <= m_found_d;
            m_idx_q      <= m_idx_d;
            f_found_q    <= f_found_d;
            f_idx_q      <= f_idx_d;
            o_idx_q      <= o_idx_d;
            o_age_q      <= o_age_d;
            steal_pend_q <= steal_pend_d;
            adr_q        <= adr_d;
            val_q        <= val_d;
            note_on_q    <= note_on_d;
            steal_q      <= steal_d;
            gate_q       <= gate_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < VOICES; i++) begin
                key_q[i] <= key_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign bus.ev_ready    = (state_q == IDLE);
    assign bus.cur_key_adr = adr_q;
    assign bus.cur_key_val = val_q;
    assign bus.note_on     = note_on_q;
    assign bus.steal       = steal_q;
    assign bus.voice_gate  = gate_q;
    assign bus.active_cnt  = cnt_q;
    assign bus.fsm_state   = state_q;
endmodule
